// File: rtl/binary_search_engine_if.sv
// binary_search_engine_if: start/done handshake, RAM read port and result bus of the search engine
//   start, target                    request side, driven by the front end
//   mem_addr, mem_rdata              read port of the sorted RAM (1-cycle latency)
//   busy, done, found, result_addr   status and result
//   master: front end / RAM side; slave: the engine
interface binary_search_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [DATA_W-1:0] target;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W:0]   result_addr;
  modport master (output start, target, mem_rdata, input mem_addr, busy, done, found, result_addr);
  modport slave  (input start, target, mem_rdata, output mem_addr, busy, done, found, result_addr);
endinterface

// File: rtl/binary_search_engine.sv
// binary_search_engine: binary search for target in an ascending-sorted external RAM of DEPTH words
//   clk, reset   clock, synchronous active-high reset
//   bus (slave)  start/target request, mem_addr/mem_rdata RAM read port,
//                busy/done/found/result_addr status and result
//   BSEARCH_LOWER_BOUND_EN: when defined, a miss reports the insertion index (final lo)
//                           instead of 0
module binary_search_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input logic clk,
  input logic reset,
  binary_search_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PROBE, WAIT, CMP, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W:0]   lo, hi, mid, mid_q;
  logic [ADDR_W+1:0] sum;
  logic [DATA_W-1:0] target_q;
  // Sum kept one bit wider so lo+hi can never wrap before the halving.
  assign sum = {1'b0, lo} + {1'b0, hi};
  assign mid = sum[ADDR_W+1:1];
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE, DONE: state_n = bus.start ? PROBE : state;
      PROBE:      state_n = lo < hi ? WAIT : DONE;
      WAIT:       state_n = CMP;
      CMP:        state_n = bus.mem_rdata == target_q ? DONE : PROBE;
      default:    state_n = IDLE;
    endcase
  end
  always_comb bus.busy = state == PROBE || state == WAIT || state == CMP;
  always_ff @(posedge clk)
    if (reset) begin
      lo              <= '0;
      hi              <= '0;
      mid_q           <= '0;
      target_q        <= '0;
      bus.mem_addr    <= '0;
      bus.done        <= 1'b0;
      bus.found       <= 1'b0;
      bus.result_addr <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (bus.start) begin
            target_q  <= bus.target;
            lo        <= '0;
            hi        <= (ADDR_W+1)'(DEPTH);
            bus.done  <= 1'b0;
            bus.found <= 1'b0;
          end
        PROBE:
          if (lo < hi) begin
            bus.mem_addr <= mid[ADDR_W-1:0];
            mid_q        <= mid;
          end else begin
            bus.done  <= 1'b1;
            bus.found <= 1'b0;
`ifdef BSEARCH_LOWER_BOUND_EN
            bus.result_addr <= lo;
`else
            bus.result_addr <= '0;
`endif
          end
        CMP:
          if (bus.mem_rdata == target_q) begin
            bus.found       <= 1'b1;
            bus.done        <= 1'b1;
            bus.result_addr <= mid_q;
          end else if (bus.mem_rdata < target_q) lo <= mid_q + 1'b1;
          else hi <= mid_q;
        default: ;
      endcase
endmodule

// File: tb/tb_binary_search_engine.sv
// tb_binary_search_engine: directed test of binary_search_engine over a 32-word RAM holding mem[i]=2i+1
module tb_binary_search_engine;
`ifdef BSEARCH_LOWER_BOUND_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] mem [32];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  binary_search_engine_if #(.DATA_W(8), .ADDR_W(5)) bus ();
  binary_search_engine #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always_ff @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic run(input logic [7:0] t, input int exp_n, input logic exp_found,
                     input logic [5:0] exp_addr, input logic [4:0] exp_maddr, input bit glitch);
    int n;
    @(negedge clk);
    bus.start = 1'b1;
    bus.target = t;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("done_cleared", bus.done, 0);
    check("found_cleared", bus.found, 0);
    n = 0;
    while (!bus.done && n < 40) begin
      bus.start = glitch && n == 5;
      if (glitch && n == 5) bus.target = 8'd33;
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    check("done_edge", n, exp_n);
    check("found", bus.found, exp_found);
    check("result_addr", bus.result_addr, exp_addr);
    check("busy_in_done", bus.busy, 0);
    check("last_probe_addr", bus.mem_addr, exp_maddr);
    repeat (3) @(posedge clk);
    #1;
    check("done_held", bus.done, 1);
    check("addr_held", bus.mem_addr, exp_maddr);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i + 1);
    bus.start = 1'b0;
    bus.target = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_found", bus.found, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_result", bus.result_addr, 0);
    reset = 1'b0;
    run(8'd33, 3, 1'b1, 6'd16, 5'd16, 1'b0);
    run(8'd1, 18, 1'b1, 6'd0, 5'd0, 1'b0);
    run(8'd63, 15, 1'b1, 6'd31, 5'd31, 1'b0);
    run(8'd64, 16, 1'b0, LB ? 6'd32 : 6'd0, 5'd31, 1'b0);
    run(8'd20, 16, 1'b0, LB ? 6'd10 : 6'd0, 5'd9, 1'b1);
    run(8'd0, 19, 1'b0, 6'd0, 5'd0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.target = 8'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("second_probe_addr", bus.mem_addr, 8);
    check("busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_found", bus.found, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_result", bus.result_addr, 0);
    @(posedge clk);
    #1;
    check("idle_after_rst", bus.busy, 0);
    run(8'd33, 3, 1'b1, 6'd16, 5'd16, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/binary_search_engine.md
# binary_search_engine

Parametrised binary-search accelerator that finds an unsigned `target` in an externally held, ascending-sorted RAM of `DEPTH` words. It merges control and datapath into one block, drives the RAM read port directly, and reports hit/miss with a start/done handshake. It supersedes the fixed 32×8 search pair and sits between the switch/key front end and the on-chip sorted array.

## Interface
- `DATA_W`, default 8: word width of the RAM and of `target`.
- `ADDR_W`, default 5: RAM address width.
- `DEPTH`, default 32: number of valid words, indices 0..DEPTH-1. Legal range is 1 ≤ DEPTH ≤ 2^ADDR_W.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request a search. Sampled only in IDLE or DONE.
- `target`  in  DATA_W  value to find. Latched on an accepted `start`.
- `mem_addr`  out  ADDR_W  registered RAM read address.
- `mem_rdata`  in  DATA_W  RAM read data. Valid one cycle after `mem_addr` is presented.
- `busy`  out  1  search in progress.
- `done`  out  1  result valid. Level signal, held until the next accepted `start` or reset.
- `found`  out  1  valid while `done`. 1 means a match.
- `result_addr`  out  ADDR_W+1  matching index, or the not-found value (see Configuration).

## Operation
- The search uses a half-open interval: `lo` and `hi` are each ADDR_W+1 bits; `mid = (lo+hi)>>1`, computed at ADDR_W+1 bits with no overflow.
- IDLE: `busy=0`, `done=0`. On `start`: set `target_q<=target`, `lo<=0`, `hi<=DEPTH`, go to PROBE.
- PROBE:
  - If `lo<hi`: `mem_addr<=mid[ADDR_W-1:0]`, `mid_q<=mid`, go to WAIT.
  - Otherwise: `found<=0`, `done<=1`, go to DONE.
- WAIT: one RAM-latency cycle. `mem_addr` is stable. Go to CMP.
- CMP:
  - `mem_rdata==target_q`: `found<=1`, `result_addr<=mid_q`, `done<=1`, go to DONE.
  - `mem_rdata<target_q`: `lo<=mid_q+1`, go to PROBE.
  - Otherwise: `hi<=mid_q`, go to PROBE.
- DONE: outputs hold. `start` restarts exactly as from IDLE; `done` and `found` clear on that edge.
- `start` in PROBE, WAIT or CMP is ignored. `target` changes while busy are ignored.
- Duplicates: the first index probed that matches is returned. This is deterministic because `mid` is floored.
- `busy=1` in PROBE, WAIT and CMP.
- Reset (any state, including mid-search): state goes to IDLE and all outputs are 0, i.e. `busy`, `done`, `found`, `mem_addr`, `result_addr`. Internal `lo`, `hi`, `target_q` and `mid_q` are also cleared.
- All comparisons are unsigned.

## Timing
- Edge E0 samples `start`. Each probe takes 3 cycles (PROBE, WAIT, CMP).
- Hit on probe k: `done` and `found` rise at edge E(3k).
- Miss after k probes: `done` rises at edge E(3k+1).
- Worst case is ceil(log2(DEPTH+1)) probes. For DEPTH=32 that is 6 probes, so `done` is valid by E19.
- `mem_addr` changes only on the PROBE→WAIT edge. It is otherwise held, including in DONE.
- Back-to-back operation: `start` high in DONE sampled at edge En gives `busy=1` after En, with the new search timed from En.

## Configuration
- `BSEARCH_LOWER_BOUND_EN`
  - Defined: on a miss, `result_addr` = final `lo`. This is the insertion index, i.e. the first index whose word is greater than `target`, in range 0..DEPTH. The value DEPTH means the target is greater than every word.
  - Undefined: on a miss, `result_addr`=0.
  - Hit behaviour and timing are identical in both builds.

## Test plan
All scenarios use DEPTH=32, DATA_W=8, ADDR_W=5, a 1-cycle-latency RAM model, and `mem[i]=2i+1`.

- Target 33 → first probe hits at address 16; `done`=`found`=1 at E3; `result_addr`=16.
- Target 1 → probe sequence 16,8,4,2,1,0; hit at E18; `result_addr`=0.
- Target 63 → probe sequence 16,24,28,30,31; hit at E15; `result_addr`=31.
- Target 64 → 5 probes, `lo=hi=32`; `done`=1, `found`=0 at E16; `result_addr`=32 with the macro, 0 without.
- Target 20 → miss; with the macro `result_addr`=10, without it 0. A `start` pulse mid-search is ignored, and probe timing is unchanged.
- Reset asserted during WAIT of the second probe → next cycle all outputs are 0 and state is IDLE. A subsequent `start` with target 33 completes at E3 from the new start.
